// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main controller: state encodings,
// opcodes, ALUOp codes (also consumed by ALU_Decoder) and the control vector.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;
  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXECUTE = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_BEQ     = 4'd8;
  localparam state_t S_BNE     = 4'd9;
  localparam state_t S_ADDIEX  = 4'd10;
  localparam state_t S_ORIEX   = 4'd11;
  localparam state_t S_IMMWB   = 4'd12;
  localparam state_t S_JUMP    = 4'd13;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 3'b100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic               mem_write;
    logic               ir_write;
    logic               iord;
    logic               pc_write;
    logic               branch;
    logic               branch_ne;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
  } ctrl_t;

  // First state after DECODE for a given opcode; FETCH marks an unsupported opcode.
  function automatic state_t dispatch_state(input logic [OP_W-1:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXECUTE;
      OP_BEQ:       s = S_BEQ;
      OP_BNE:       s = S_BNE;
      OP_ADDI:      s = S_ADDIEX;
      OP_ORI:       s = S_ORIEX;
      OP_J:         s = S_JUMP;
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return dispatch_state(op) != S_FETCH;
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath/memory bundle: opcode and mem_ready in, control strobes
// and mux selects out. master = controller side, slave = datapath side.
interface main_control_fsm_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               MemWrite;
  logic               IRWrite;
  logic               IorD;
  logic               PCWrite;
  logic               Branch;
  logic               BranchNE;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic               illegal_op;

  modport master (
    input  opcode, mem_ready,
    output MemWrite, IRWrite, IorD, PCWrite, Branch, BranchNE, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  MemWrite, IRWrite, IorD, PCWrite, Branch, BranchNE, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op
  );

endinterface

// File: rtl/main_ctrl_out_decode.sv
// Output decode of the main controller: current state -> control vector.
// Only FETCH (mem_ready handshake) and DECODE (illegal opcode flag) look at inputs.
module main_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_supported(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe is held for the whole wait so the memory sees a stable request.
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_BEQ;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_BNE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_BNE;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch_ne = 1'b1;
      end
      S_ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ORI;
      end
      S_IMMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: state register and next-state logic; the
// per-state control outputs come from main_ctrl_out_decode.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  main_control_fsm_if.master bus
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;

  // Asynchronous clear abandons any in-flight instruction, including a pending store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_next = dispatch_state(bus.opcode);
      S_MEMADR:  state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_IMMWB;
      S_ORIEX:   state_next = S_IMMWB;
      // Writeback, branch, jump and unused encodings all return to FETCH.
      default:   state_next = S_FETCH;
    endcase
  end

  main_ctrl_out_decode u_out_decode (
    .state     (state_reg),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.IorD       = ctrl.iord;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.Branch     = ctrl.branch;
  assign bus.BranchNE   = ctrl.branch_ne;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_main_control_fsm.sv
// Testbench for main_control_fsm: directed scenarios plus random instruction streams
// checked cycle by cycle against per-instruction step recipes.
module tb_main_control_fsm;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_BNE  = 6'b000101;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_J    = 6'b000010;

  // Step kinds of an instruction recipe
  localparam int K_FETCH  = 0;
  localparam int K_DECODE = 1;
  localparam int K_ADDR   = 2;
  localparam int K_READ   = 3;
  localparam int K_LOADWB = 4;
  localparam int K_WRITE  = 5;
  localparam int K_ALU    = 6;
  localparam int K_ALUWB  = 7;
  localparam int K_BEQ    = 8;
  localparam int K_BNE    = 9;
  localparam int K_ORI    = 10;
  localparam int K_IMMWB  = 11;
  localparam int K_JUMP   = 12;

  typedef struct packed {
    logic       mw, irw, iord, pcw, br, bne, rw, rd, m2r, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       ill;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rec_q[$];

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] got_vec;
  assign got_vec = {bus.MemWrite, bus.IRWrite, bus.IorD, bus.PCWrite, bus.Branch,
                    bus.BranchNE, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                    bus.ALUSrcB, bus.PCSrc, bus.ALUOp, bus.illegal_op};

  function automatic bit legal(input logic [5:0] op);
    return op inside {OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_ADDI, OPC_ORI, OPC_J};
  endfunction

  function automatic logic [5:0] pick_legal(input int idx);
    case (idx)
      0: return OPC_R;
      1: return OPC_LW;
      2: return OPC_SW;
      3: return OPC_BEQ;
      4: return OPC_BNE;
      5: return OPC_ADDI;
      6: return OPC_ORI;
      default: return OPC_J;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] op);
    case (op)
      OPC_J, OPC_BEQ, OPC_BNE: return 3;
      OPC_LW:                  return 5;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit waits_on_mem(input int kind);
    return kind == K_FETCH || kind == K_READ || kind == K_WRITE;
  endfunction

  function automatic logic [17:0] expect_vec(input int kind, input logic [5:0] op, input logic mr);
    vec_t v;
    v = '0;
    case (kind)
      K_FETCH:  begin v.irw = mr; v.pcw = mr; v.asb = 2'b01; end
      K_DECODE: begin v.asb = 2'b11; v.ill = !legal(op); end
      K_ADDR:   begin v.asa = 1'b1; v.asb = 2'b10; end
      K_READ:   begin v.iord = 1'b1; end
      K_LOADWB: begin v.rw = 1'b1; v.m2r = 1'b1; end
      K_WRITE:  begin v.iord = 1'b1; v.mw = 1'b1; end
      K_ALU:    begin v.asa = 1'b1; v.aop = 3'b010; end
      K_ALUWB:  begin v.rw = 1'b1; v.rd = 1'b1; end
      K_BEQ:    begin v.asa = 1'b1; v.aop = 3'b001; v.pcs = 2'b01; v.br = 1'b1; end
      K_BNE:    begin v.asa = 1'b1; v.aop = 3'b100; v.pcs = 2'b01; v.bne = 1'b1; end
      K_ORI:    begin v.asa = 1'b1; v.asb = 2'b10; v.aop = 3'b011; end
      K_IMMWB:  begin v.rw = 1'b1; end
      K_JUMP:   begin v.pcw = 1'b1; v.pcs = 2'b10; end
      default:  ;
    endcase
    return v;
  endfunction

  task automatic build_recipe(input logic [5:0] op);
    rec_q.delete();
    rec_q.push_back(K_FETCH);
    rec_q.push_back(K_DECODE);
    case (op)
      OPC_LW:   begin rec_q.push_back(K_ADDR); rec_q.push_back(K_READ); rec_q.push_back(K_LOADWB); end
      OPC_SW:   begin rec_q.push_back(K_ADDR); rec_q.push_back(K_WRITE); end
      OPC_R:    begin rec_q.push_back(K_ALU); rec_q.push_back(K_ALUWB); end
      OPC_BEQ:  rec_q.push_back(K_BEQ);
      OPC_BNE:  rec_q.push_back(K_BNE);
      OPC_ADDI: begin rec_q.push_back(K_ADDR); rec_q.push_back(K_IMMWB); end
      OPC_ORI:  begin rec_q.push_back(K_ORI); rec_q.push_back(K_IMMWB); end
      OPC_J:    rec_q.push_back(K_JUMP);
      default:  ;
    endcase
  endtask

  // Runs one instruction starting at its FETCH cycle; pct = chance of mem_ready per cycle.
  task automatic run_instr(input logic [5:0] op, input int pct, output int cyc);
    logic [17:0] exp_v;
    logic        mr;
    int          waits;
    bit          again;
    cyc = 0;
    build_recipe(op);
    foreach (rec_q[i]) begin
      waits = 0;
      do begin
        @(negedge clk);
        mr = (waits >= 8) ? 1'b1 : ($urandom_range(99) < pct);
        bus.opcode    = op;
        bus.mem_ready = mr;
        #1;
        exp_v = expect_vec(rec_q[i], op, mr);
        checks++;
        if (got_vec !== exp_v) begin
          errors++;
          $display("FAIL step op=%b kind=%0d cyc=%0d got=%h exp=%h", op, rec_q[i], cyc, got_vec, exp_v);
        end
        cyc++;
        waits++;
        again = waits_on_mem(rec_q[i]) && !mr;
      end while (again);
    end
    $display("instr op=%b cycles=%0d", op, cyc);
  endtask

  task automatic test_reset;
    bus.opcode    = OPC_R;
    bus.mem_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (got_vec !== expect_vec(K_FETCH, OPC_R, 1'b0)) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", got_vec, expect_vec(K_FETCH, OPC_R, 1'b0));
    end
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (got_vec !== expect_vec(K_FETCH, OPC_R, 1'b1)) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", got_vec, expect_vec(K_FETCH, OPC_R, 1'b1));
    end
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_rtype;
    int cyc;
    run_instr(OPC_R, 100, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL rtype_cycles got=%0d exp=4", cyc); end
  endtask

  task automatic test_lw_wait;
    logic [7:0] mr_bits;
    int iord_cnt;
    int m2r_cnt;
    mr_bits  = 8'b11000111;
    iord_cnt = 0;
    m2r_cnt  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.opcode    = OPC_LW;
      bus.mem_ready = mr_bits[c];
      #1;
      if (bus.IorD === 1'b1) iord_cnt++;
      if (bus.MemtoReg === 1'b1) m2r_cnt++;
    end
    checks++;
    if (iord_cnt !== 4) begin errors++; $display("FAIL lw_iord_cycles got=%0d exp=4", iord_cnt); end
    checks++;
    if (m2r_cnt !== 1) begin errors++; $display("FAIL lw_memtoreg_cycles got=%0d exp=1", m2r_cnt); end
    $display("lw with 3 wait states: iord=%0d memtoreg=%0d", iord_cnt, m2r_cnt);
  endtask

  task automatic test_branches;
    int cyc;
    run_instr(OPC_BNE, 100, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL bne_cycles got=%0d exp=3", cyc); end
    run_instr(OPC_BEQ, 100, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL beq_cycles got=%0d exp=3", cyc); end
  endtask

  task automatic test_ori;
    int cyc;
    run_instr(OPC_ORI, 100, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL ori_cycles got=%0d exp=4", cyc); end
  endtask

  task automatic test_illegal;
    int ill_cnt;
    int wr_cnt;
    ill_cnt = 0;
    wr_cnt  = 0;
    // FETCH, DECODE(illegal), FETCH, DECODE(j), JUMP
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.opcode    = (c < 2) ? 6'b111111 : OPC_J;
      bus.mem_ready = 1'b1;
      #1;
      if (bus.illegal_op === 1'b1) ill_cnt++;
      if (c < 3 && (bus.MemWrite | bus.RegWrite) !== 1'b0) wr_cnt++;
    end
    checks++;
    if (ill_cnt !== 1) begin errors++; $display("FAIL illegal_pulse got=%0d exp=1", ill_cnt); end
    checks++;
    if (wr_cnt !== 0) begin errors++; $display("FAIL illegal_writes got=%0d exp=0", wr_cnt); end
    $display("illegal opcode: pulses=%0d", ill_cnt);
  endtask

  task automatic test_latency;
    logic [5:0] op;
    int n;
    bit pending;
    pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op = pick_legal(i);
      if (!pending) begin
        @(negedge clk);
        bus.mem_ready = 1'b1;
      end
      bus.opcode = op;
      #1;
      n = 1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk); #1;
        if (bus.ALUSrcB === 2'b01 && bus.IRWrite === 1'b1) break;
        n++;
      end
      pending = 1'b1;
      checks++;
      if (n !== latency(op)) begin
        errors++; $display("FAIL latency op=%b got=%0d exp=%0d", op, n, latency(op));
      end
      $display("latency op=%b cycles=%0d", op, n);
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    // R-type reset in EXECUTE
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.opcode = OPC_R; bus.mem_ready = 1'b1; #1;
    end
    checks++;
    if (bus.ALUOp !== 3'b010) begin errors++; $display("FAIL mid_exec_aluop got=%b exp=010", bus.ALUOp); end
    reset = 1'b0;
    #1;
    checks++;
    if (got_vec !== expect_vec(K_FETCH, OPC_R, 1'b1)) begin
      errors++; $display("FAIL reset_in_exec got=%h exp=%h", got_vec, expect_vec(K_FETCH, OPC_R, 1'b1));
    end
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ((bus.MemWrite | bus.RegWrite) !== 1'b0) begin
      errors++; $display("FAIL reset_exec_strobe got=%b exp=0", bus.MemWrite | bus.RegWrite);
    end
    reset = 1'b1;
    // sw reset while stalled in the write
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); bus.opcode = OPC_SW; bus.mem_ready = (c < 3); #1;
    end
    checks++;
    if (bus.MemWrite !== 1'b1) begin errors++; $display("FAIL sw_stall_memwrite got=%b exp=1", bus.MemWrite); end
    reset = 1'b0;
    #1;
    checks++;
    if (got_vec !== expect_vec(K_FETCH, OPC_SW, 1'b0)) begin
      errors++; $display("FAIL reset_in_memwr got=%h exp=%h", got_vec, expect_vec(K_FETCH, OPC_SW, 1'b0));
    end
    @(negedge clk); #1;
    checks++;
    if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwr_hold got=%b exp=0", bus.MemWrite); end
    reset = 1'b1;
    $display("reset mid-instruction done");
  endtask

  task automatic test_random;
    logic [5:0] op;
    int sel;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(9));
      op  = (sel < 8) ? pick_legal(sel) : 6'($urandom_range(63));
      run_instr(op, 60, cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branches();
    test_ori();
    test_illegal();
    test_latency();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
